// File: rtl/bf16_dot_seq.sv
// bf16_dot_seq: BF16 dot-product sequencer driving an external pipelined FMA through NUM_ACC interleaved partial sums
module bf16_dot_seq #(
    parameter int LEN_W = 8,
    parameter int NUM_ACC = 4,
    localparam int TAG_W = $clog2(NUM_ACC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [15:0]      cmd_init,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic             fma_req_valid,
    input  logic             fma_req_ready,
    output logic [15:0]      fma_op_a,
    output logic [15:0]      fma_op_b,
    output logic [15:0]      fma_op_c,
    output logic [TAG_W-1:0] fma_req_tag,
    input  logic             fma_rsp_valid,
    output logic             fma_rsp_ready,
    input  logic [15:0]      fma_rsp_result,
    input  logic [TAG_W-1:0] fma_rsp_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic             busy
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_REDUCE, S_OUT} state_t;
    state_t             r_state, w_next;
    logic [15:0]        r_acc [NUM_ACC];
    logic [NUM_ACC-1:0] r_pend, w_set, w_clr;
    logic [LEN_W-1:0]   r_issued, r_len;
    logic [TAG_W-1:0]   r_j, w_lane;
    logic               w_fire, w_rsp, w_cmd, w_red;

    assign w_lane        = r_issued[TAG_W-1:0];
    assign w_red         = r_state == S_REDUCE;
    assign w_fire        = fma_req_valid & fma_req_ready;
    assign w_rsp         = fma_rsp_valid & r_pend[fma_rsp_tag];
    assign w_cmd         = cmd_valid & cmd_ready;
    assign w_set         = {{(NUM_ACC-1){1'b0}}, w_fire} << fma_req_tag;
    assign w_clr         = {{(NUM_ACC-1){1'b0}}, w_rsp} << fma_rsp_tag;
    assign cmd_ready     = rst_n & (r_state == S_IDLE);
    assign fma_rsp_ready = rst_n;
    assign in_ready      = (r_state == S_ACCUM) & w_fire;
    assign out_valid     = r_state == S_OUT;
    assign out_result    = out_valid ? r_acc[0] : 16'h0000;
    assign busy          = r_state != S_IDLE;
    // Reduction folds acc[j] into acc[0] as acc[j]*1.0 + acc[0]
    assign fma_op_a      = w_red ? r_acc[r_j] : in_a;
    assign fma_op_b      = w_red ? 16'h3F80 : in_b;
    assign fma_op_c      = w_red ? r_acc[0] : r_acc[w_lane];
    assign fma_req_tag   = w_red ? '0 : w_lane;
    assign fma_req_valid = ((r_state == S_ACCUM) & in_valid & ~r_pend[w_lane] & (r_issued != r_len))
                         | (w_red & (r_j != '0) & ~r_pend[0]);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_cmd) w_next = S_ACCUM;
            S_ACCUM:  if (r_issued == r_len && r_pend == '0) w_next = S_REDUCE;
            S_REDUCE: if (r_j == '0 && !r_pend[0]) w_next = S_OUT;
            S_OUT:    if (out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pend   <= '0;
            r_issued <= '0;
            r_len    <= '0;
            r_j      <= '0;
            for (int i = 0; i < NUM_ACC; i++) r_acc[i] <= 16'h0000;
        end else begin
            r_state <= w_next;
            r_pend  <= (r_pend & ~w_clr) | w_set;
            if (w_rsp) r_acc[fma_rsp_tag] <= fma_rsp_result;
            if (w_fire && r_state == S_ACCUM) r_issued <= r_issued + 1'b1;
            // r_j wraps to 0 after the last partial is issued, marking reduction done
            if (w_fire && w_red) r_j <= r_j + 1'b1;
            if (w_cmd) begin
                r_len    <= cmd_len;
                r_issued <= '0;
                r_j      <= TAG_W'(1);
                for (int i = 0; i < NUM_ACC; i++) r_acc[i] <= (i == 0) ? cmd_init : 16'h0000;
            end
        end
    end
endmodule
